// File: rtl/dot_product_stream_if.sv
// dot_product_stream_if
//   Operand and result streams of the dot-product engine.
//   slave  : the engine's view (takes operands and downstream ready, drives the result).
//   master : the producer/consumer view (drives operands and downstream ready).
//   row_in/col_in : LANES elements per beat, lane 0 is the lowest element index.
//   axiiv/axiir   : operand beat valid/ready.
//   axiod/axiov   : full-precision result and its valid.
//   axior         : downstream ready for the result.
interface dot_product_stream_if #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 19
);
  logic [LANES-1:0][DATA_WIDTH-1:0] row_in;
  logic [LANES-1:0][DATA_WIDTH-1:0] col_in;
  logic                             axiiv;
  logic                             axiir;
  logic [ACC_WIDTH-1:0]             axiod;
  logic                             axiov;
  logic                             axior;

  modport slave (
    input  row_in, col_in, axiiv, axior,
    output axiir, axiod, axiov
  );

  modport master (
    output row_in, col_in, axiiv, axior,
    input  axiir, axiod, axiov
  );
endinterface

// File: rtl/dot_product_stream.sv
// dot_product_stream
//   Two-stage pipelined dot product of a ROW_SIZE-element row and column,
//   LANES elements per beat. Stage 1 registers the lane products, stage 2
//   adds them into the accumulator and publishes the result on the last beat.
//   A pending, unconsumed result freezes the whole pipeline.
//
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     s   : dot_product_stream_if.slave (operand stream in, result stream out)
//
//   Build option:
//     DOT_SIGNED_EN : when defined, elements are two's complement and all
//                     extensions are sign-extensions; otherwise unsigned.
module dot_product_stream #(
  parameter int ROW_SIZE   = 8,
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  dot_product_stream_if.slave s
);
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(ROW_SIZE);
  localparam int BEATS     = ROW_SIZE / LANES;
  localparam int PW        = 2 * DATA_WIDTH;
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic                     p_valid_q, p_valid_d;
  logic                     p_first_q, p_first_d;
  logic                     p_last_q, p_last_d;
  logic [LANES-1:0][PW-1:0] prod_q, prod_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [ACC_WIDTH-1:0]     axiod_q, axiod_d;
  logic                     axiov_q, axiov_d;

  logic                     stall;
  logic                     accept;
  logic [ACC_WIDTH-1:0]     lane_sum;
  logic [ACC_WIDTH-1:0]     acc_sum;

  // Element widened to product width before multiplying, so the truncated
  // PW-bit product is exact in either number format.
  function automatic logic [PW-1:0] ext_op(input logic [DATA_WIDTH-1:0] v);
`ifdef DOT_SIGNED_EN
    return PW'($signed(v));
`else
    return PW'(v);
`endif
  endfunction

  function automatic logic [ACC_WIDTH-1:0] ext_prod(input logic [PW-1:0] v);
`ifdef DOT_SIGNED_EN
    return ACC_WIDTH'($signed(v));
`else
    return ACC_WIDTH'(v);
`endif
  endfunction

  // Only an unconsumed result can stall; axiir never looks at axiiv.
  assign stall   = axiov_q && !s.axior;
  assign accept  = s.axiiv && !stall;
  assign s.axiir = !stall;
  assign s.axiod = axiod_q;
  assign s.axiov = axiov_q;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    p_valid_d  = p_valid_q;
    p_first_d  = p_first_q;
    p_last_d   = p_last_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    axiod_d    = axiod_q;
    axiov_d    = axiov_q;

    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + ext_prod(prod_q[i]);
    end
    acc_sum = (p_first_q ? '0 : acc_q) + lane_sum;

    if (!stall) begin
      p_valid_d = accept;
      if (accept) begin
        beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
        p_first_d  = (beat_cnt_q == '0);
        p_last_d   = (beat_cnt_q == LAST_BEAT);
        for (int i = 0; i < LANES; i++) begin
          prod_d[i] = ext_op(s.row_in[i]) * ext_op(s.col_in[i]);
        end
      end
      // Not stalled means any held result is being taken on this edge.
      axiov_d = 1'b0;
      if (p_valid_q) begin
        acc_d = acc_sum;
        if (p_last_q) begin
          axiod_d = acc_sum;
          axiov_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      p_valid_q  <= 1'b0;
      p_first_q  <= 1'b0;
      p_last_q   <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      axiod_q    <= '0;
      axiov_q    <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      p_valid_q  <= p_valid_d;
      p_first_q  <= p_first_d;
      p_last_q   <= p_last_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      axiod_q    <= axiod_d;
      axiov_q    <= axiov_d;
    end
  end
endmodule

// File: tb/tb_dot_product_stream.sv
module tb_dot_product_stream;
  localparam int ROW = 8;
  localparam int L   = 4;
  localparam int DW  = 8;
  localparam int AW  = 19;

  typedef logic [DW-1:0] vec_t [ROW];
  typedef logic [L-1:0][DW-1:0] beat_t;
  typedef struct {
    logic [AW-1:0] val;
    int            due;
    bit            chk;
  } exp_t;

`ifdef DOT_SIGNED_EN
  localparam logic [AW-1:0] EXP_FULL = 19'd8;
  localparam logic [AW-1:0] EXP_SIGN = 19'h7FFF0;
`else
  localparam logic [AW-1:0] EXP_FULL = 19'd520200;
  localparam logic [AW-1:0] EXP_SIGN = 19'd4080;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_d = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   seen = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dot_product_stream_if #(.LANES(L), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  dot_product_stream #(.ROW_SIZE(ROW), .LANES(L), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  // Monitor: checks the handshake model and pops the scoreboard on transfer.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
      if (rst_d) begin
        checks++;
        if (bus.axiov !== 1'b0 || bus.axiod !== '0 || bus.axiir !== 1'b1) begin
          failures++;
          $display("FAIL reset_state got axiov=%b axiod=%0d axiir=%b exp 0/0/1",
                   bus.axiov, bus.axiod, bus.axiir);
        end
      end
    end else begin
      checks++;
      if (bus.axiir !== !(bus.axiov && !bus.axior)) begin
        failures++;
        $display("FAIL axiir got=%b exp=%b (axiov=%b axior=%b)", bus.axiir,
                 !(bus.axiov && !bus.axior), bus.axiov, bus.axior);
      end
      if (bus.axiov === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got axiod=%0d exp no result at cycle %0d",
                   bus.axiod, cyc);
        end else begin
          if (bus.axiod !== exp_q[0].val) begin
            failures++;
            $display("FAIL axiod got=%0d exp=%0d", bus.axiod, exp_q[0].val);
          end
          if (!seen && exp_q[0].chk) begin
            checks++;
            if (cyc != exp_q[0].due) begin
              failures++;
              $display("FAIL latency got cycle=%0d exp cycle=%0d", cyc, exp_q[0].due);
            end
          end
          seen = 1'b1;
          if (bus.axior) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  function automatic vec_t fill(input logic [DW-1:0] v);
    vec_t r;
    for (int i = 0; i < ROW; i++) r[i] = v;
    return r;
  endfunction

  function automatic vec_t ramp_up();
    vec_t r;
    for (int i = 0; i < ROW; i++) r[i] = DW'(i + 1);
    return r;
  endfunction

  function automatic vec_t ramp_down();
    vec_t r;
    for (int i = 0; i < ROW; i++) r[i] = DW'(ROW - i);
    return r;
  endfunction

  task automatic send_beat(input beat_t rb, input beat_t cb);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    bus.row_in = rb;
    bus.col_in = cb;
    bus.axiiv  = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.axiir;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got no accept in %0d cycles exp accept", n);
    end
  endtask

  task automatic send_vec(input vec_t r, input vec_t c, input logic [AW-1:0] e,
                          input bit chk);
    beat_t rb, cb;
    exp_t  x;
    for (int b = 0; b < ROW / L; b++) begin
      for (int i = 0; i < L; i++) begin
        rb[i] = r[b * L + i];
        cb[i] = c[b * L + i];
      end
      send_beat(rb, cb);
    end
    bus.axiiv = 1'b0;
    x.val = e;
    x.due = cyc + 1;
    x.chk = chk;
    exp_q.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got %0d results pending exp 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t ffb;
    bus.row_in = '0;
    bus.col_in = '0;
    bus.axiiv  = 1'b0;
    bus.axior  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic with latency check
    send_vec(ramp_up(), fill(8'd1), 19'd36, 1'b1);
    drain();

    // Full scale
    send_vec(fill(8'hFF), fill(8'hFF), EXP_FULL, 1'b1);
    drain();

    // Backpressure: result held while the next vector waits
    send_vec(ramp_up(), fill(8'd1), 19'd36, 1'b0);
    bus.axior = 1'b0;
    fork
      begin
        repeat (6) @(posedge clk);
        #1 bus.axior = 1'b1;
      end
    join_none
    send_vec(fill(8'hFF), fill(8'hFF), EXP_FULL, 1'b0);
    drain();

    // Streaming, no gaps
    send_vec(fill(8'd2), fill(8'd3), 19'd48, 1'b1);
    send_vec(fill(8'd1), fill(8'd1), 19'd8, 1'b1);
    send_vec(ramp_up(), ramp_down(), 19'd120, 1'b1);
    drain();

    // Sign mode
    send_vec(fill(8'hFF), fill(8'h02), EXP_SIGN, 1'b1);
    drain();

    // Reset mid-vector
    for (int i = 0; i < L; i++) ffb[i] = 8'hFF;
    send_beat(ffb, ffb);
    bus.axiiv = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_vec(ramp_up(), fill(8'd1), 19'd36, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
